// File: rtl/or_shift_pkg.sv
// Shared types and constants for the OR-shift accumulate writer.
package or_shift_pkg;

  localparam int unsigned DEF_DEPTH = 256;
  localparam int unsigned DEF_W     = 32;
  localparam int unsigned DEF_AW    = $clog2(DEF_DEPTH);
  localparam int unsigned DEF_SW    = $clog2(DEF_W) + 1;
  localparam int unsigned WRCOUNT_W = 16;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } fsm_t;

  // Stage-1 write request: target word and the pre-shifted OR mask
  typedef struct packed {
    logic [DEF_AW-1:0] addr;
    logic [DEF_W-1:0]  mask;
  } wr_req_t;

endpackage

// File: rtl/or_shift_writer_if.sv
// Request/read/status bundle between producers, consumers and the writer.
interface or_shift_writer_if
  import or_shift_pkg::*;
#(
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned W  = DEF_W,
  parameter int unsigned SW = DEF_SW,
  parameter int unsigned CW = WRCOUNT_W
);

  logic          IN_clear;
  logic          IN_valid;
  logic          OUT_ready;
  logic [AW-1:0] IN_addr;
  logic [W-1:0]  IN_data;
  logic [SW-1:0] IN_shamt;
  logic [AW-1:0] IN_rdAddr;
  logic [W-1:0]  OUT_rdData;
  logic          OUT_busy;
  logic [CW-1:0] OUT_wrCount;

  modport master (
    output IN_clear, IN_valid, IN_addr, IN_data, IN_shamt, IN_rdAddr,
    input  OUT_ready, OUT_rdData, OUT_busy, OUT_wrCount
  );

  modport slave (
    input  IN_clear, IN_valid, IN_addr, IN_data, IN_shamt, IN_rdAddr,
    output OUT_ready, OUT_rdData, OUT_busy, OUT_wrCount
  );

endinterface

// File: rtl/or_mem_1r1w.sv
// DEPTH x W memory: registered read (read-before-write, sync clear) and a
// bit-masked synchronous write port.
module or_mem_1r1w #(
  parameter  int unsigned DEPTH = 256,
  parameter  int unsigned W     = 32,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rd_clr,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [W-1:0]  wr_bits
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rd_clr) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

  // Only bits selected by wr_bits change; lets OR-accumulate skip a read
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= (mem[wr_addr] & ~wr_bits) | (wr_data & wr_bits);
    end
  end

endmodule

// File: rtl/or_shift_writer.sv
// Write-side owner of a bit-accumulate memory: clear sweep FSM, two-stage
// shift/OR write pipeline, saturating write counter and registered read port.
module or_shift_writer
  import or_shift_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned W     = DEF_W
) (
  input  logic             clk,
  input  logic             rst,
  or_shift_writer_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = $clog2(W) + 1;

  fsm_t                 state_q;
  fsm_t                 state_d;
  logic [AW-1:0]        ptr_q;
  logic [AW-1:0]        ptr_d;
  logic                 ready_c;
  logic                 busy_c;
  logic                 accept_c;
  logic                 clear_req_c;
  logic [W-1:0]         mask_c;
  wr_req_t              pipe_q;
  logic                 pipe_vld_q;
  logic [WRCOUNT_W-1:0] cnt_q;
  logic                 mem_wr_en;
  logic [AW-1:0]        mem_wr_addr;
  logic [W-1:0]         mem_wr_data;
  logic [W-1:0]         mem_wr_bits;
  logic                 rd_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    ready_c     = 1'b0;
    busy_c      = 1'b0;
    clear_req_c = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        busy_c = 1'b1;
        ptr_d  = ptr_q + AW'(1);
        if (ptr_q == AW'(DEPTH - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        ready_c = ~bus.IN_clear;
        if (bus.IN_clear) begin
          clear_req_c = 1'b1;
          state_d     = ST_CLEAR;
          ptr_d       = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  assign accept_c = bus.IN_valid & ready_c;

  // Shifts of W or more push every bit out of the word
  assign mask_c = (bus.IN_shamt >= SW'(W)) ? '0 : W'(bus.IN_data << bus.IN_shamt);

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      pipe_vld_q <= accept_c;
      if (clear_req_c) begin
        cnt_q <= '0;
      end else if (accept_c && (cnt_q != '1)) begin
        cnt_q <= cnt_q + WRCOUNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept_c) begin
      pipe_q.addr <= DEF_AW'(bus.IN_addr);
      pipe_q.mask <= DEF_W'(mask_c);
    end
  end

  // Sweep owns the write port while clearing; stage 2 can never overlap it
  always_comb begin
    mem_wr_en   = 1'b0;
    mem_wr_addr = AW'(pipe_q.addr);
    mem_wr_data = W'(pipe_q.mask);
    mem_wr_bits = W'(pipe_q.mask);
    if (state_q == ST_CLEAR) begin
      mem_wr_en   = ~rst;
      mem_wr_addr = ptr_q;
      mem_wr_data = '0;
      mem_wr_bits = '1;
    end else if (pipe_vld_q) begin
      mem_wr_en = ~rst;
    end
  end

  // Read data is held at zero on every cycle spent in the sweep
  assign rd_clr = rst | (state_q == ST_CLEAR) | (state_d == ST_CLEAR);

  or_mem_1r1w #(
    .DEPTH(DEPTH),
    .W    (W)
  ) u_mem (
    .clk    (clk),
    .rd_clr (rd_clr),
    .rd_addr(bus.IN_rdAddr),
    .rd_data(bus.OUT_rdData),
    .wr_en  (mem_wr_en),
    .wr_addr(mem_wr_addr),
    .wr_data(mem_wr_data),
    .wr_bits(mem_wr_bits)
  );

  assign bus.OUT_ready   = ready_c;
  assign bus.OUT_busy    = busy_c;
  assign bus.OUT_wrCount = cnt_q;

endmodule

// File: tb/tb_or_shift_writer.sv
// Directed bench for or_shift_writer: clear sweeps, shift/OR writes, read timing.
module tb_or_shift_writer;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  or_shift_writer_if #(.AW(8), .W(32), .SW(6), .CW(16)) bus ();

  or_shift_writer #(.DEPTH(256), .W(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [5:0] s);
    bus.IN_valid = 1'b1;
    bus.IN_addr  = a;
    bus.IN_data  = d;
    bus.IN_shamt = s;
    tick();
    bus.IN_valid = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] v);
    bus.IN_rdAddr = a;
    tick();
    v = bus.OUT_rdData;
  endtask

  // Expects to be called in sweep cycle 0; ends in the first run cycle
  task automatic sweep_check(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (bus.OUT_busy !== 1'b1 || bus.OUT_ready !== 1'b0 || bus.OUT_rdData !== 32'h0) bad++;
      tick();
    end
    chk({tag, "_busy_cycles"}, 32'(bad), 32'h0);
    chk({tag, "_ready_end"}, 32'(bus.OUT_ready), 32'h1);
    chk({tag, "_busy_end"}, 32'(bus.OUT_busy), 32'h0);
  endtask

  task automatic all_zero(input string tag);
    logic [31:0] v;
    int bad;
    bad = 0;
    for (int a = 0; a < 256; a++) begin
      rd(8'(a), v);
      if (v !== 32'h0) bad++;
    end
    chk(tag, 32'(bad), 32'h0);
  endtask

  initial begin
    logic [31:0] v;
    n_chk = 0;
    n_err = 0;
    rst           = 1'b1;
    bus.IN_clear  = 1'b0;
    bus.IN_valid  = 1'b0;
    bus.IN_addr   = '0;
    bus.IN_data   = '0;
    bus.IN_shamt  = '0;
    bus.IN_rdAddr = '0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_wrcount", 32'(bus.OUT_wrCount), 32'h0);
    chk("rst_rddata", bus.OUT_rdData, 32'h0);
    sweep_check("init");
    all_zero("init_words");

    // Single write, read two cycles later
    wr(8'd5, 32'h1, 6'd3);
    tick();
    rd(8'd5, v);
    chk("w5_data", v, 32'h8);
    chk("w5_count", 32'(bus.OUT_wrCount), 32'd1);

    // Back-to-back writes to one word, including shamt W-1
    wr(8'd7, 32'h1, 6'd0);
    wr(8'd7, 32'h1, 6'd31);
    wr(8'd7, 32'hF0, 6'd4);
    tick();
    rd(8'd7, v);
    chk("w7_data", v, 32'h8000_0F01);
    chk("w7_count", 32'(bus.OUT_wrCount), 32'd4);

    // Shift of W drops everything but still counts
    wr(8'd9, 32'hFFFF_FFFF, 6'd32);
    tick();
    rd(8'd9, v);
    chk("w9_data", v, 32'h0);
    chk("w9_count", 32'(bus.OUT_wrCount), 32'd5);

    // Upper bits truncated
    wr(8'd10, 32'h0000_00FF, 6'd28);
    tick();
    rd(8'd10, v);
    chk("w10_data", v, 32'hF000_0000);
    chk("w10_count", 32'(bus.OUT_wrCount), 32'd6);

    // Read-before-write timing around a single write
    bus.IN_valid = 1'b1;
    bus.IN_addr  = 8'd3;
    bus.IN_data  = 32'h1;
    bus.IN_shamt = 6'd0;
    tick();
    bus.IN_valid  = 1'b0;
    bus.IN_rdAddr = 8'd3;
    tick();
    chk("rbw_old", bus.OUT_rdData, 32'h0);
    tick();
    chk("rbw_new", bus.OUT_rdData, 32'h1);
    chk("rbw_count", 32'(bus.OUT_wrCount), 32'd7);

    // Clear with a write still in flight; reads of word 7 must stay forced low
    bus.IN_rdAddr = 8'd7;
    wr(8'd11, 32'h1, 6'd2);
    bus.IN_clear = 1'b1;
    bus.IN_valid = 1'b1;
    bus.IN_addr  = 8'd12;
    #1;
    chk("clr_ready", 32'(bus.OUT_ready), 32'h0);
    tick();
    bus.IN_clear = 1'b0;
    bus.IN_valid = 1'b0;
    chk("clr_count", 32'(bus.OUT_wrCount), 32'h0);
    sweep_check("clr");
    chk("clr_count_end", 32'(bus.OUT_wrCount), 32'h0);
    all_zero("clr_words");

    // Reset in the middle of a sweep restarts it
    wr(8'd20, 32'h3, 6'd1);
    bus.IN_clear = 1'b1;
    tick();
    bus.IN_clear = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sweep_check("rst_mid");
    chk("rst_mid_count", 32'(bus.OUT_wrCount), 32'h0);
    rd(8'd20, v);
    chk("rst_mid_w20", v, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
